// File: rtl/demux_stream.sv
// demux_stream: registered 1-to-N_OUT valid/ready stream demultiplexer with packet-level routing.
// Define DEMUX_STATS_EN to enable the forwarded/dropped packet counters; otherwise they read 0.
module demux_stream #(
  parameter int N_OUT  = 2,
  parameter int SEL_W  = 1,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  output logic [N_OUT-1:0]        out_last,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    drop_pulse,
  output logic [15:0]             pkt_count,
  output logic [15:0]             drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_n_s;
  logic [SEL_W-1:0]   dest_r;
  logic [SEL_W-1:0]   dest_n_s;
  logic [SEL_W-1:0]   load_dest_s;
  logic               hold_valid_r;
  logic               hold_last_r;
  logic [DATA_W-1:0]  hold_data_r;
  logic [SEL_W-1:0]   hold_dest_r;
  logic               sel_ok_s;
  logic               lane_ready_s;
  logic               pass_ready_s;
  logic               drain_s;
  logic               in_ready_s;
  logic               load_s;
  logic               drop_last_s;
  logic               drop_pulse_r;

  // N_OUT fits in SEL_W+1 bits, so the widened compare is exact.
  assign sel_ok_s = ({1'b0, sel} < (SEL_W + 1)'(N_OUT));

  // Ready of whichever lane the holding register currently targets.
  always_comb begin
    lane_ready_s = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      lane_ready_s = lane_ready_s | (out_ready[k] & (hold_dest_r == SEL_W'(k)));
    end
  end

  assign drain_s      = hold_valid_r && lane_ready_s;
  assign pass_ready_s = !rst && (!hold_valid_r || lane_ready_s);
  assign in_ready     = in_ready_s;

  // Packet FSM: decides readiness, loads and drops for the current beat.
  always_comb begin
    state_n_s   = state_r;
    dest_n_s    = dest_r;
    load_dest_s = dest_r;
    in_ready_s  = 1'b0;
    load_s      = 1'b0;
    drop_last_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sel_ok_s) begin
          in_ready_s = pass_ready_s;
          if (in_valid && in_ready_s) begin
            load_s      = 1'b1;
            load_dest_s = sel;
            dest_n_s    = sel;
            state_n_s   = in_last ? IDLE : FWD;
          end else begin
            state_n_s = IDLE;
          end
        end else begin
          // Unroutable packets are swallowed without ever stalling ingress.
          in_ready_s = !rst;
          if (in_valid && in_ready_s) begin
            drop_last_s = in_last;
            state_n_s   = in_last ? IDLE : DROP;
          end else begin
            state_n_s = IDLE;
          end
        end
      end
      FWD: begin
        in_ready_s = pass_ready_s;
        if (in_valid && in_ready_s) begin
          load_s    = 1'b1;
          state_n_s = in_last ? IDLE : FWD;
        end else begin
          state_n_s = FWD;
        end
      end
      DROP: begin
        in_ready_s = !rst;
        if (in_valid && in_ready_s) begin
          drop_last_s = in_last;
          state_n_s   = in_last ? IDLE : DROP;
        end else begin
          state_n_s = DROP;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state and latched packet destination.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      dest_r  <= '0;
    end else begin
      state_r <= state_n_s;
      dest_r  <= dest_n_s;
    end
  end

  // Single holding register; a load wins over a drain so full throughput is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_last_r  <= 1'b0;
      hold_data_r  <= '0;
      hold_dest_r  <= '0;
    end else if (load_s) begin
      hold_valid_r <= 1'b1;
      hold_last_r  <= in_last;
      hold_data_r  <= in_data;
      hold_dest_r  <= load_dest_s;
    end else if (drain_s) begin
      hold_valid_r <= 1'b0;
      hold_last_r  <= 1'b0;
      hold_data_r  <= '0;
      hold_dest_r  <= '0;
    end
  end

  // Drop notification, one cycle after the final dropped beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_pulse_r <= 1'b0;
    end else begin
      drop_pulse_r <= drop_last_s;
    end
  end

  assign drop_pulse = drop_pulse_r;

  // Lane decode of the holding register; non-destination lanes read zero.
  always_comb begin
    out_valid = '0;
    out_last  = '0;
    out_data  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k]                 = hold_valid_r && (hold_dest_r == SEL_W'(k));
      out_last[k]                  = out_valid[k] & hold_last_r;
      out_data[k*DATA_W +: DATA_W] = out_valid[k] ? hold_data_r : '0;
    end
  end

`ifdef DEMUX_STATS_EN
  logic [15:0] pkt_count_r;
  logic [15:0] drop_count_r;

  // Wrapping packet statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count_r  <= 16'd0;
      drop_count_r <= 16'd0;
    end else begin
      if (drain_s && hold_last_r) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      if (drop_last_s) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end
  end

  assign pkt_count  = pkt_count_r;
  assign drop_count = drop_count_r;
`else
  assign pkt_count  = 16'd0;
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Scoreboard bench for demux_stream (N_OUT=3, SEL_W=2); counter expectations follow DEMUX_STATS_EN.
module tb_demux_stream;

  localparam int N_OUT  = 3;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 8;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;
  logic [SEL_W-1:0]        sel;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_last;
  logic [N_OUT-1:0]        out_ready;
  logic                    drop_pulse;
  logic [15:0]             pkt_count;
  logic [15:0]             drop_count;

  demux_stream #(.N_OUT(N_OUT), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .sel(sel),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .drop_pulse(drop_pulse), .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic       last;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   exp_pkts = 0;
  int   exp_drops = 0;
  int   tot_drops = 0;
  int   seen_drops = 0;
  bit   lat_en = 1'b1;
  bit   m_in_pkt = 1'b0;
  bit   m_fwd = 1'b0;
  int   m_lane = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  function automatic logic [31:0] exp_cnt(input int v);
    logic [15:0] w;
    w = v[15:0];
    return STATS ? {16'd0, w} : 32'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every handshaked lane beat must match the front of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid != 3'b000) check_eq("onehot", 32'($countones(out_valid)), 32'd1);
      for (int k = 0; k < N_OUT; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_beat", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check_eq("lane", 32'(k), 32'(e.lane));
            check_eq("data", {24'd0, out_data[k*DATA_W +: DATA_W]}, {24'd0, e.data});
            check_eq("last", {31'd0, out_last[k]}, {31'd0, e.last});
            if (e.lat) check_eq("latency", 32'(cyc - e.cyc), 32'd1);
            if (e.last) exp_pkts++;
          end
        end
      end
      if (drop_pulse) seen_drops++;
    end
  end

  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic l);
    int waited;
    bit fwd;
    int lane;
    in_valid = 1'b1; sel = s; in_data = d; in_last = l;
    if (m_in_pkt) begin
      fwd = m_fwd; lane = m_lane;
    end else begin
      fwd = (s < 2'd3); lane = int'(s);
    end
    waited = 0;
    @(negedge clk);
    if (!fwd) check_eq("drop_ready", {31'd0, in_ready}, 32'd1);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
    end else begin
      if (lat_en) check_eq("no_stall", 32'(waited), 32'd0);
      if (fwd) exp_q.push_back('{lane, d, l, cyc, lat_en});
      if (!fwd && l) begin
        exp_drops++;
        tot_drops++;
      end
      m_in_pkt = !l; m_fwd = fwd; m_lane = lane;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_in_pkt = 1'b0; exp_pkts = 0; exp_drops = 0;
  endtask

  // Abandon a packet after its first beat, then start a new single-beat packet.
  task automatic mid_reset(input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] d);
    send(s1, d, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_data = d + 8'd1; in_last = 1'b0; sel = s1;
    @(negedge clk);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete(); m_in_pkt = 1'b0; exp_pkts = 0; exp_drops = 0;
    @(negedge clk);
    check_eq("rst_out_valid", {29'd0, out_valid}, 32'd0);
    check_eq("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
    @(posedge clk); #1;
    send(s2, d + 8'd2, 1'b1);
    idle(3);
    check_eq("rst_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sel = '0; out_ready = '1;
    @(negedge clk);
    check_eq("reset_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_out_valid", {29'd0, out_valid}, 32'd0);
    check_eq("reset_out_data", {8'd0, out_data}, 32'd0);
    check_eq("reset_out_last", {29'd0, out_last}, 32'd0);
    check_eq("reset_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    check_eq("reset_pkt_count", {16'd0, pkt_count}, 32'd0);
    check_eq("reset_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge clk); #1;

    // Three-beat packet to lane 1.
    send(2'd1, 8'hA1, 1'b0);
    send(2'd1, 8'hA2, 1'b0);
    send(2'd1, 8'hA3, 1'b1);
    idle(3);
    check_eq("t1_pkt_count", {16'd0, pkt_count}, exp_cnt(exp_pkts));

    // Back-to-back packets; sel moves mid-packet without effect.
    do_reset(1);
    send(2'd0, 8'hB1, 1'b0);
    send(2'd1, 8'hB2, 1'b1);
    send(2'd1, 8'hC1, 1'b1);
    send(2'd2, 8'hD1, 1'b1);
    idle(3);
    check_eq("t2_pkt_count", {16'd0, pkt_count}, exp_cnt(exp_pkts));

    // Lane 0 backpressure for four cycles mid-packet.
    lat_en = 1'b0;
    send(2'd0, 8'hE1, 1'b0);
    out_ready[0] = 1'b0;
    in_valid = 1'b1; sel = 2'd0; in_data = 8'hE2; in_last = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("bp_hold_data", {24'd0, out_data[7:0]}, 32'h0000_00E1);
      check_eq("bp_out_valid", {29'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    send(2'd0, 8'hE2, 1'b0);
    send(2'd0, 8'hE3, 1'b1);
    idle(3);
    lat_en = 1'b1;
    check_eq("bp_drained", 32'(exp_q.size()), 32'd0);

    // Drops: two-beat, single-beat, and one with sel changing inside the drop.
    do_reset(1);
    send(2'd3, 8'hF1, 1'b0);
    send(2'd3, 8'hF2, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("drop_pulse_hi", {31'd0, drop_pulse}, 32'd1);
    check_eq("drop_count_1", {16'd0, drop_count}, exp_cnt(exp_drops));
    check_eq("drop_no_valid", {29'd0, out_valid}, 32'd0);
    @(negedge clk);
    check_eq("drop_pulse_lo", {31'd0, drop_pulse}, 32'd0);
    @(posedge clk); #1;
    send(2'd3, 8'h61, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("drop1_pulse_hi", {31'd0, drop_pulse}, 32'd1);
    @(negedge clk);
    check_eq("drop1_pulse_lo", {31'd0, drop_pulse}, 32'd0);
    @(posedge clk); #1;
    send(2'd3, 8'h71, 1'b0);
    send(2'd0, 8'h72, 1'b0);
    send(2'd1, 8'h73, 1'b1);
    send(2'd0, 8'h74, 1'b1);
    idle(3);
    check_eq("drop_count_3", {16'd0, drop_count}, exp_cnt(exp_drops));
    check_eq("drop_pkt_count", {16'd0, pkt_count}, exp_cnt(exp_pkts));

    // Reset in the middle of packets.
    mid_reset(2'd0, 2'd0, 8'h30);
    mid_reset(2'd1, 2'd2, 8'h40);

    // Packet counter wrap.
    do_reset(1);
    for (int i = 0; i < 65535; i++) send(2'd0, i[7:0], 1'b1);
    idle(2);
    check_eq("pkt_count_ffff", {16'd0, pkt_count}, exp_cnt(exp_pkts));
    send(2'd0, 8'h5A, 1'b1);
    idle(2);
    check_eq("pkt_count_wrap", {16'd0, pkt_count}, exp_cnt(exp_pkts));

    check_eq("final_drained", 32'(exp_q.size()), 32'd0);
    check_eq("drop_pulses", 32'(seen_drops), 32'(tot_drops));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
